// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
//  - arb_state_e : FSM state encoding (IDLE=0, BUSY_IF=1, BUSY_DP=2)
//  - cnt_w()     : bit width for a counter holding values 0..n-1
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_DP = 2'd2
    } arb_state_e;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch port (IF)
// and the load/store port (DP). One access in flight at a time.
// Ports:
//  clk_i, rst_i (async, active-high)
//  if_*  : fetch read request / grant / read data return
//  dp_*  : load/store request / grant / data return, dp_busy_o stall
//  err_o : pulses alongside rvalid when an access timed out
//  mem_* : memory strobe, fields and completion handshake
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            if_req_i,
    input  logic [AW-1:0]   if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [DW-1:0]   if_rdata_o,
    input  logic            dp_req_i,
    input  logic            dp_we_i,
    input  logic [AW-1:0]   dp_addr_i,
    input  logic [DW-1:0]   dp_wdata_i,
    input  logic [DW/8-1:0] dp_be_i,
    output logic            dp_gnt_o,
    output logic            dp_rvalid_o,
    output logic [DW-1:0]   dp_rdata_o,
    output logic            dp_busy_o,
    output logic            err_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    output logic [DW/8-1:0] mem_be_o,
    input  logic            mem_ready_i,
    input  logic [DW-1:0]   mem_rdata_i
);

    localparam int BW = DW / 8;
    localparam int SW = cnt_w(STARVE_MAX + 1);
    localparam int TW = cnt_w(TIMEOUT);
    localparam logic [SW-1:0] LP_STARVE_MAX = SW'(STARVE_MAX);
    localparam logic [TW-1:0] LP_TMO_LAST   = TW'(TIMEOUT - 1);

    arb_state_e     r_state;
    logic           r_mem_req;
    logic           r_we;
    logic [AW-1:0]  r_addr;
    logic [DW-1:0]  r_wdata;
    logic [BW-1:0]  r_be;
    logic [SW-1:0]  r_starve;
    logic [TW-1:0]  r_tmo;
    logic           r_if_rvalid;
    logic           r_dp_rvalid;
    logic           r_err;
    logic [DW-1:0]  r_if_rdata;
    logic [DW-1:0]  r_dp_rdata;

    logic w_idle;
    logic w_if_win;
    logic w_if_gnt;
    logic w_dp_gnt;
    logic w_tmo_last;

    // DP normally wins a collision; IF wins once it has lost STARVE_MAX times.
    always_comb begin
        w_idle     = (r_state == ST_IDLE);
        w_if_win   = if_req_i & (~dp_req_i | (r_starve == LP_STARVE_MAX));
        w_if_gnt   = w_idle & w_if_win;
        w_dp_gnt   = w_idle & dp_req_i & ~w_if_win;
        w_tmo_last = (r_tmo == LP_TMO_LAST);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_starve    <= '0;
            r_tmo       <= '0;
            r_if_rvalid <= 1'b0;
            r_dp_rvalid <= 1'b0;
            r_err       <= 1'b0;
            r_if_rdata  <= '0;
            r_dp_rdata  <= '0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_dp_rvalid <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_if_gnt) begin
                        r_state   <= ST_BUSY_IF;
                        r_mem_req <= 1'b1;
                        r_we      <= 1'b0;
                        r_addr    <= if_addr_i;
                        r_wdata   <= '0;
                        r_be      <= '1;
                        r_tmo     <= '0;
                        r_starve  <= '0;
                    end else if (w_dp_gnt) begin
                        r_state   <= ST_BUSY_DP;
                        r_mem_req <= 1'b1;
                        r_we      <= dp_we_i;
                        r_addr    <= dp_addr_i;
                        r_wdata   <= dp_we_i ? dp_wdata_i : '0;
                        r_be      <= dp_we_i ? dp_be_i : '1;
                        r_tmo     <= '0;
                        // IF lost this cycle: count toward forced win
                        if (if_req_i && r_starve != LP_STARVE_MAX)
                            r_starve <= r_starve + SW'(1);
                    end
                end
                ST_BUSY_IF, ST_BUSY_DP: begin
                    // ready takes priority over a timeout on the same cycle
                    if (mem_ready_i || w_tmo_last) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                        r_we      <= 1'b0;
                        r_err     <= ~mem_ready_i;
                        if (r_state == ST_BUSY_IF) begin
                            r_if_rvalid <= 1'b1;
                            r_if_rdata  <= mem_ready_i ? mem_rdata_i : '0;
                        end else begin
                            r_dp_rvalid <= 1'b1;
                            r_dp_rdata  <= (mem_ready_i && !r_we) ? mem_rdata_i : '0;
                        end
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign if_gnt_o    = w_if_gnt;
    assign dp_gnt_o    = w_dp_gnt;
    assign if_rvalid_o = r_if_rvalid;
    assign if_rdata_o  = r_if_rdata;
    assign dp_rvalid_o = r_dp_rvalid;
    assign dp_rdata_o  = r_dp_rdata;
    assign err_o       = r_err;
    assign dp_busy_o   = dp_req_i | (r_state == ST_BUSY_DP) | r_dp_rvalid;
    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign mem_be_o    = r_be;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: requester processes drive directed vectors,
// a memory responder answers with per-vector latency/data, and a monitor
// pops expected responses from per-port scoreboards on every rvalid.
module tb_mem_port_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] mdata;   // data memory returns
        int          lat;     // cycles of mem_req before ready, -1 = never
        logic [31:0] erd;     // expected rdata
        logic        eerr;    // expected err
    } req_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    typedef struct {
        bit dp;
        int c;
    } glog_t;

    logic        clk_i, rst_i;
    logic        if_req_i, if_gnt_o, if_rvalid_o;
    logic [31:0] if_addr_i, if_rdata_o;
    logic        dp_req_i, dp_we_i, dp_gnt_o, dp_rvalid_o, dp_busy_o, err_o;
    logic [31:0] dp_addr_i, dp_wdata_i, dp_rdata_o;
    logic [3:0]  dp_be_i, mem_be_o;
    logic        mem_req_o, mem_we_o, mem_ready_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    mem_port_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dp_req_i(dp_req_i), .dp_we_i(dp_we_i), .dp_addr_i(dp_addr_i),
        .dp_wdata_i(dp_wdata_i), .dp_be_i(dp_be_i), .dp_gnt_o(dp_gnt_o),
        .dp_rvalid_o(dp_rvalid_o), .dp_rdata_o(dp_rdata_o), .dp_busy_o(dp_busy_o),
        .err_o(err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    req_t  if_stim[$], dp_stim[$], mem_q[$];
    exp_t  if_q[$], dp_q[$];
    glog_t gnt_log[$];

    bit if_taken = 0, dp_taken = 0;
    int if_rv_cyc = 0, mstart = 0, last_len = 0, mcyc = 0;
    req_t icur, dcur, mcur;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic push_if(input logic [31:0] a, input logic [31:0] md, input int lat,
                           input logic [31:0] erd, input logic eerr);
        req_t r;
        r = '{1'b0, a, 32'h0, 4'h0, md, lat, erd, eerr};
        if_stim.push_back(r);
    endtask

    task automatic push_dp(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, input logic [31:0] md, input int lat,
                           input logic [31:0] erd, input logic eerr);
        req_t r;
        r = '{we, a, wd, be, md, lat, erd, eerr};
        dp_stim.push_back(r);
    endtask

    // IF requester: holds request until granted, pushes expectation on issue
    initial begin
        if_req_i = 0; if_addr_i = 0;
        forever begin
            @(negedge clk_i);
            if (if_taken) begin if_req_i = 0; if_taken = 0; end
            if (!if_req_i && if_stim.size() > 0 && !rst_i) begin
                icur = if_stim.pop_front();
                if_addr_i = icur.addr;
                if_req_i = 1;
                if_q.push_back('{icur.erd, icur.eerr});
            end
            #1;
            if (if_req_i && if_gnt_o) begin
                if_taken = 1;
                mem_q.push_back(icur);
                gnt_log.push_back('{1'b0, cyc});
            end
        end
    end

    // DP requester
    initial begin
        dp_req_i = 0; dp_we_i = 0; dp_addr_i = 0; dp_wdata_i = 0; dp_be_i = 0;
        forever begin
            @(negedge clk_i);
            if (dp_taken) begin dp_req_i = 0; dp_taken = 0; end
            if (!dp_req_i && dp_stim.size() > 0 && !rst_i) begin
                dcur = dp_stim.pop_front();
                dp_we_i = dcur.we; dp_addr_i = dcur.addr;
                dp_wdata_i = dcur.wdata; dp_be_i = dcur.be;
                dp_req_i = 1;
                dp_q.push_back('{dcur.erd, dcur.eerr});
            end
            #1;
            if (dp_req_i && dp_gnt_o) begin
                dp_taken = 1;
                mem_q.push_back(dcur);
                gnt_log.push_back('{1'b1, cyc});
            end
        end
    end

    // Memory responder: checks access fields on the first cycle of mem_req
    initial begin
        mem_ready_i = 0; mem_rdata_i = 32'hBAD0BAD0;
        forever begin
            @(negedge clk_i);
            if (mem_req_o) begin
                if (mcyc == 0) begin
                    mstart = cyc;
                    if (mem_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL mem_unexpected_access: got addr %0h required no access", mem_addr_o);
                        mcur = '{1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 1'b0};
                    end else begin
                        mcur = mem_q.pop_front();
                        chk("mem_we", mem_we_o, mcur.we);
                        chk("mem_addr", mem_addr_o, mcur.addr);
                        chk("mem_be", mem_be_o, mcur.we ? mcur.be : 4'hF);
                        if (mcur.we) chk("mem_wdata", mem_wdata_o, mcur.wdata);
                    end
                end
                mem_ready_i = (mcur.lat >= 0) && (mcyc == mcur.lat);
                mem_rdata_i = mem_ready_i ? mcur.mdata : 32'hBAD0BAD0;
                mcyc++;
            end else begin
                if (mcyc != 0) last_len = mcyc;
                mcyc = 0;
                mem_ready_i = 0;
                mem_rdata_i = 32'hBAD0BAD0;
            end
        end
    end

    // Response monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (if_rvalid_o) begin
                if_rv_cyc = cyc;
                if (if_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL if_unexpected_rvalid: got rvalid required none");
                end else begin
                    e = if_q.pop_front();
                    chk("if_rdata", if_rdata_o, e.rd);
                    chk("if_err", err_o, e.err);
                end
            end
            if (dp_rvalid_o) begin
                if (dp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL dp_unexpected_rvalid: got rvalid required none");
                end else begin
                    e = dp_q.pop_front();
                    chk("dp_rdata", dp_rdata_o, e.rd);
                    chk("dp_err", err_o, e.err);
                end
            end
            if (err_o && !if_rvalid_o && !dp_rvalid_o) begin
                n_chk++; n_fail++;
                $display("FAIL stray_err: got err without rvalid required none");
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((if_stim.size() > 0 || dp_stim.size() > 0 || if_req_i || dp_req_i ||
                mem_req_o || if_q.size() > 0 || dp_q.size() > 0) && n < 300) begin
            @(negedge clk_i); #3;
            n++;
        end
        chk("idle_reached", (n < 300), 1);
        repeat (2) @(negedge clk_i);
        #3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, base, n, busy_gap;
        bit exp_ord[8];
        rst_i = 1;
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_be", mem_be_o, 0);
        chk("rst_rvalid", {if_rvalid_o, dp_rvalid_o, err_o}, 0);
        chk("rst_busy", dp_busy_o, 0);
        chk("rst_rdata", {if_rdata_o, dp_rdata_o}, 0);
        #1 rst_i = 0;

        // 1: single IF read, ready in first mem_req cycle
        push_if(32'h100, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1'b0);
        wait_idle();
        g = gnt_log[gnt_log.size()-1].c;
        chk("t1_memreq_lat", mstart - g, 1);
        chk("t1_rvalid_lat", if_rv_cyc - g, 2);

        // 2: collision, DP store wins, IF served next
        base = gnt_log.size();
        push_dp(1'b1, 32'h20, 32'h12345678, 4'b0011, 32'hFFFFFFFF, 0, 32'h0, 1'b0);
        push_if(32'h104, 32'h55AA55AA, 1, 32'h55AA55AA, 1'b0);
        wait_idle();
        chk("t2_ngnt", gnt_log.size() - base, 2);
        if (gnt_log.size() >= base + 2) begin
            chk("t2_first_dp", gnt_log[base].dp, 1);
            chk("t2_second_if", gnt_log[base+1].dp, 0);
        end

        // 3: starvation, order DDDDIDDI
        base = gnt_log.size();
        exp_ord = '{1, 1, 1, 1, 0, 1, 1, 0};
        push_if(32'h400, 32'hA1A1A1A1, 0, 32'hA1A1A1A1, 1'b0);
        push_if(32'h404, 32'hA2A2A2A2, 0, 32'hA2A2A2A2, 1'b0);
        push_dp(1'b0, 32'h500, 32'h0, 4'h0, 32'hD1D1D1D1, 0, 32'hD1D1D1D1, 1'b0);
        push_dp(1'b0, 32'h504, 32'h0, 4'h0, 32'hD2D2D2D2, 1, 32'hD2D2D2D2, 1'b0);
        push_dp(1'b0, 32'h508, 32'h0, 4'h0, 32'hD3D3D3D3, 0, 32'hD3D3D3D3, 1'b0);
        push_dp(1'b0, 32'h50C, 32'h0, 4'h0, 32'hD4D4D4D4, 2, 32'hD4D4D4D4, 1'b0);
        push_dp(1'b0, 32'h510, 32'h0, 4'h0, 32'hD5D5D5D5, 0, 32'hD5D5D5D5, 1'b0);
        push_dp(1'b0, 32'h514, 32'h0, 4'h0, 32'hD6D6D6D6, 0, 32'hD6D6D6D6, 1'b0);
        wait_idle();
        chk("t3_ngnt", gnt_log.size() - base, 8);
        for (int k = 0; k < 8; k++)
            if (gnt_log.size() > base + k)
                chk($sformatf("t3_order%0d", k), gnt_log[base+k].dp, exp_ord[k]);

        // 4: DP load timeout
        push_dp(1'b0, 32'h80, 32'h0, 4'h0, 32'h0, -1, 32'h0, 1'b1);
        wait_idle();
        chk("t4_memreq_len", last_len, 16);
        chk("t4_if_rdata_hold", if_rdata_o, 32'hA2A2A2A2);

        // 5: reset mid BUSY_DP
        push_dp(1'b0, 32'h40, 32'h0, 4'h0, 32'h0, -1, 32'h0, 1'b1);
        n = 0;
        while (!mem_req_o && n < 50) begin @(negedge clk_i); #3; n++; end
        chk("t5_access_started", mem_req_o, 1);
        repeat (3) @(negedge clk_i);
        #2 rst_i = 1;
        #1;
        chk("t5_rst_memreq", mem_req_o, 0);
        chk("t5_rst_busy", dp_busy_o, 0);
        dp_q.delete();
        mem_q.delete();
        repeat (2) @(negedge clk_i);
        #2 rst_i = 0;
        repeat (4) @(negedge clk_i);
        #2;
        push_if(32'h200, 32'hCAFEF00D, 1, 32'hCAFEF00D, 1'b0);
        wait_idle();
        chk("t5_if_after_rst", gnt_log[gnt_log.size()-1].dp, 0);

        // 6: back-to-back DP loads
        base = gnt_log.size();
        push_dp(1'b0, 32'h300, 32'h0, 4'h0, 32'h11111111, 0, 32'h11111111, 1'b0);
        push_dp(1'b0, 32'h304, 32'h0, 4'h0, 32'h22222222, 0, 32'h22222222, 1'b0);
        push_dp(1'b0, 32'h308, 32'h0, 4'h0, 32'h33333333, 0, 32'h33333333, 1'b0);
        busy_gap = 0;
        n = 0;
        do begin
            @(negedge clk_i); #3;
            if (!dp_busy_o) busy_gap++;
            n++;
        end while ((dp_stim.size() > 0 || dp_q.size() > 0) && n < 100);
        chk("t6_busy_gap", busy_gap, 0);
        wait_idle();
        chk("t6_ngnt", gnt_log.size() - base, 3);
        for (int k = 1; k < 3; k++)
            if (gnt_log.size() > base + k)
                chk($sformatf("t6_gap%0d", k), gnt_log[base+k].c - gnt_log[base+k-1].c, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
